mem_queue_nbeat: RTL

- Parametrised successor to the 2-beat RVV memory queue.
- Bridges one RVV_DATA_WIDTH vector port to a narrow MBUS_DATA_WIDTH AXI-like bus using BEATS = RVV_DATA_WIDTH/MBUS_DATA_WIDTH beats per element, issuing and reassembling beats in order.
- Adds read credit control, per-beat write strobes with zero-strobe skipping, and AW/W decoupling.
- Adds load/store group completion flags, plus a store error flag.

---
 rtl/mem_queue_nbeat.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_queue_nbeat.sv
// Vector-port to narrow-bus memory queue: splits each RVV element into BEATS bus
// beats for loads (AR/R with credit control) and stores (AW/W/B with strobe skipping).
module mem_queue_nbeat #(
  parameter int unsigned MBUS_ADDR_WIDTH = 32,
  parameter int unsigned MBUS_DATA_WIDTH = 32,
  parameter int unsigned RVV_DATA_WIDTH  = 128,
  parameter int unsigned FIFO_DEPTH_BITS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rvv_ld_req,
  input  logic [MBUS_ADDR_WIDTH-1:0]   rvv_ld_addr,
  input  logic                         rvv_ld_last,
  output logic                         rvv_ld_ready,
  output logic [RVV_DATA_WIDTH-1:0]    rvv_data_in,
  output logic                         rvv_valid_in,
  input  logic                         rvv_ready_out,
  output logic                         rvv_done_ld,
  input  logic                         rvv_st_valid,
  input  logic [MBUS_ADDR_WIDTH-1:0]   rvv_st_addr,
  input  logic [RVV_DATA_WIDTH-1:0]    rvv_st_data,
  input  logic [RVV_DATA_WIDTH/8-1:0]  rvv_st_be,
  input  logic                         rvv_st_last,
  output logic                         rvv_st_ready,
  output logic                         rvv_done_st,
  output logic                         rvv_st_err,
  output logic [MBUS_ADDR_WIDTH-1:0]   mbus_ar_addr,
  output logic                         mbus_ar_valid,
  input  logic                         mbus_ar_ready,
  input  logic [MBUS_DATA_WIDTH-1:0]   mbus_r_data,
  input  logic                         mbus_r_valid,
  output logic                         mbus_r_ready,
  output logic [MBUS_ADDR_WIDTH-1:0]   mbus_aw_addr,
  output logic                         mbus_aw_valid,
  input  logic                         mbus_aw_ready,
  output logic [MBUS_DATA_WIDTH-1:0]   mbus_w_data,
  output logic [MBUS_DATA_WIDTH/8-1:0] mbus_w_strb,
  output logic                         mbus_w_valid,
  input  logic                         mbus_w_ready,
  input  logic                         mbus_b_resp,
  input  logic                         mbus_b_valid,
  output logic                         mbus_b_ready
);
  localparam int unsigned AW        = MBUS_ADDR_WIDTH;
  localparam int unsigned MW        = MBUS_DATA_WIDTH;
  localparam int unsigned RW        = RVV_DATA_WIDTH;
  localparam int unsigned MBUS_DW_B = MW / 8;
  localparam int unsigned RVV_DW_B  = RW / 8;
  localparam int unsigned BEATS     = RW / MW;
  localparam int unsigned BCW       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned DEPTH     = 1 << FIFO_DEPTH_BITS;
  localparam int unsigned PW        = FIFO_DEPTH_BITS;
  localparam int unsigned CW        = FIFO_DEPTH_BITS + 1;
  localparam int unsigned RSW       = CW + 1;
  localparam int unsigned OBW       = 16;

  typedef enum logic {ST_IDLE, ST_BUSY} st_state_t;

  function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] base, input logic [BCW-1:0] k);
    return (base & ~AW'(RVV_DW_B - 1)) + AW'(k) * AW'(MBUS_DW_B);
  endfunction

  function automatic logic [CW-1:0] cnt_upd(input logic [CW-1:0] c, input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   return c + CW'(1);
      2'b01:   return c - CW'(1);
      default: return c;
    endcase
  endfunction

  // Storage
  logic [AW-1:0]       r_lq_addr [DEPTH];
  logic                r_lq_last [DEPTH];
  logic                r_pl_last [DEPTH];
  logic [RW-1:0]       r_dq_data [DEPTH];
  logic                r_dq_last [DEPTH];
  logic [AW-1:0]       r_sq_addr [DEPTH];
  logic [RW-1:0]       r_sq_data [DEPTH];
  logic [RVV_DW_B-1:0] r_sq_be   [DEPTH];
  logic                r_sq_last [DEPTH];

  logic [PW-1:0]  r_lq_wp, r_lq_rp, r_pl_wp, r_pl_rp, r_dq_wp, r_dq_rp, r_sq_wp, r_sq_rp;
  logic [CW-1:0]  r_lq_cnt, r_pl_cnt, r_dq_cnt, r_sq_cnt;
  logic [BCW-1:0] r_ar_beat, r_r_beat, r_st_beat;
  logic [RW-1:0]  r_asm;
  st_state_t      r_state;
  logic           r_aw_acc, r_w_acc, r_grp_closed, r_err;
  logic [OBW-1:0] r_b_out;

  logic           w_lq_push, w_ar_hs, w_ar_end, w_pl_push, w_r_acc, w_r_end, w_dq_pop;
  logic [RSW-1:0] w_reserved;
  logic [RW-1:0]  w_asm;
  logic           w_sq_push, w_sq_pop, w_aw_hs, w_w_hs, w_beat_done, w_pop_last, w_b_dec;
  logic [BCW:0]   w_lo;
  logic           w_nz_found;
  logic [BCW-1:0] w_nz_idx, w_beat_nxt;
  logic           w_aw_acc_nxt, w_w_acc_nxt;
  st_state_t      w_state_nxt;

  // Load path: request queue, credit-gated AR walk, in-order R assembly
  assign rvv_ld_ready  = (r_lq_cnt != CW'(DEPTH));
  assign w_lq_push     = rvv_ld_req & rvv_ld_ready;
  assign w_reserved    = {1'b0, r_pl_cnt} + {1'b0, r_dq_cnt};
  assign mbus_ar_valid = (r_lq_cnt != '0) & ((r_ar_beat != '0) | (w_reserved < RSW'(DEPTH)));
  assign mbus_ar_addr  = beat_addr(r_lq_addr[r_lq_rp], r_ar_beat);
  assign w_ar_hs       = mbus_ar_valid & mbus_ar_ready;
  assign w_ar_end      = w_ar_hs & (r_ar_beat == BCW'(BEATS - 1));
  assign w_pl_push     = w_ar_hs & (r_ar_beat == '0);
  assign mbus_r_ready  = 1'b1;
  assign w_r_acc       = mbus_r_valid & (r_pl_cnt != '0);
  assign w_r_end       = w_r_acc & (r_r_beat == BCW'(BEATS - 1));
  assign rvv_valid_in  = (r_dq_cnt != '0);
  assign rvv_data_in   = r_dq_data[r_dq_rp];
  assign w_dq_pop      = rvv_valid_in & rvv_ready_out;
  assign rvv_done_ld   = w_dq_pop & r_dq_last[r_dq_rp];

  always_comb begin
    w_asm = r_asm;
    w_asm[int'(r_r_beat)*MW +: MW] = mbus_r_data;
  end

  // Store path: beat walk over non-zero strobes with independent AW/W acceptance
  assign rvv_st_ready  = (r_sq_cnt != CW'(DEPTH));
  assign w_sq_push     = rvv_st_valid & rvv_st_ready;
  assign mbus_aw_valid = (r_state == ST_BUSY) & ~r_aw_acc;
  assign mbus_w_valid  = (r_state == ST_BUSY) & ~r_w_acc;
  assign mbus_aw_addr  = beat_addr(r_sq_addr[r_sq_rp], r_st_beat);
  assign mbus_w_data   = r_sq_data[r_sq_rp][int'(r_st_beat)*MW +: MW];
  assign mbus_w_strb   = r_sq_be[r_sq_rp][int'(r_st_beat)*MBUS_DW_B +: MBUS_DW_B];
  assign w_aw_hs       = mbus_aw_valid & mbus_aw_ready;
  assign w_w_hs        = mbus_w_valid & mbus_w_ready;
  assign w_beat_done   = (r_state == ST_BUSY) & (r_aw_acc | w_aw_hs) & (r_w_acc | w_w_hs);
  assign w_lo          = (r_state == ST_IDLE) ? '0 : ({1'b0, r_st_beat} + (BCW+1)'(1));
  assign w_pop_last    = w_sq_pop & r_sq_last[r_sq_rp];
  assign mbus_b_ready  = 1'b1;
  assign w_b_dec       = mbus_b_valid & (r_b_out != '0);
  assign rvv_done_st   = r_grp_closed & (r_b_out == '0);
  assign rvv_st_err    = rvv_done_st & r_err;

  // Lowest beat at or above w_lo with a non-zero strobe
  always_comb begin
    w_nz_found = 1'b0;
    w_nz_idx   = '0;
    for (int k = BEATS - 1; k >= 0; k--) begin
      if ((r_sq_be[r_sq_rp][k*MBUS_DW_B +: MBUS_DW_B] != '0) && (k >= int'(w_lo))) begin
        w_nz_found = 1'b1;
        w_nz_idx   = BCW'(k);
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_beat_nxt   = r_st_beat;
    w_aw_acc_nxt = r_aw_acc;
    w_w_acc_nxt  = r_w_acc;
    w_sq_pop     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_sq_cnt != '0) begin
          if (w_nz_found) begin
            w_state_nxt  = ST_BUSY;
            w_beat_nxt   = w_nz_idx;
            w_aw_acc_nxt = 1'b0;
            w_w_acc_nxt  = 1'b0;
          end else begin
            w_sq_pop = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (w_beat_done) begin
          w_aw_acc_nxt = 1'b0;
          w_w_acc_nxt  = 1'b0;
          if (w_nz_found) begin
            w_beat_nxt = w_nz_idx;
          end else begin
            w_sq_pop    = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_aw_acc_nxt = r_aw_acc | w_aw_hs;
          w_w_acc_nxt  = r_w_acc | w_w_hs;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FIFO payloads need no reset; pointers and counts qualify them
  always_ff @(posedge clk) begin
    if (w_lq_push) begin
      r_lq_addr[r_lq_wp] <= rvv_ld_addr;
      r_lq_last[r_lq_wp] <= rvv_ld_last;
    end
    if (w_pl_push) r_pl_last[r_pl_wp] <= r_lq_last[r_lq_rp];
    if (w_r_end) begin
      r_dq_data[r_dq_wp] <= w_asm;
      r_dq_last[r_dq_wp] <= r_pl_last[r_pl_rp];
    end
    if (w_sq_push) begin
      r_sq_addr[r_sq_wp] <= rvv_st_addr;
      r_sq_data[r_sq_wp] <= rvv_st_data;
      r_sq_be[r_sq_wp]   <= rvv_st_be;
      r_sq_last[r_sq_wp] <= rvv_st_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lq_wp <= '0; r_lq_rp <= '0; r_lq_cnt <= '0;
      r_pl_wp <= '0; r_pl_rp <= '0; r_pl_cnt <= '0;
      r_dq_wp <= '0; r_dq_rp <= '0; r_dq_cnt <= '0;
      r_sq_wp <= '0; r_sq_rp <= '0; r_sq_cnt <= '0;
      r_ar_beat <= '0; r_r_beat <= '0; r_st_beat <= '0;
      r_asm <= '0;
      r_state <= ST_IDLE;
      r_aw_acc <= 1'b0; r_w_acc <= 1'b0;
      r_grp_closed <= 1'b0; r_err <= 1'b0;
      r_b_out <= '0;
    end else begin
      if (w_lq_push) r_lq_wp <= r_lq_wp + PW'(1);
      if (w_ar_end)  r_lq_rp <= r_lq_rp + PW'(1);
      r_lq_cnt <= cnt_upd(r_lq_cnt, w_lq_push, w_ar_end);
      if (w_ar_hs) r_ar_beat <= w_ar_end ? '0 : r_ar_beat + BCW'(1);
      if (w_pl_push) r_pl_wp <= r_pl_wp + PW'(1);
      if (w_r_end)   r_pl_rp <= r_pl_rp + PW'(1);
      r_pl_cnt <= cnt_upd(r_pl_cnt, w_pl_push, w_r_end);
      if (w_r_acc) begin
        r_asm    <= w_asm;
        r_r_beat <= w_r_end ? '0 : r_r_beat + BCW'(1);
      end
      if (w_r_end)  r_dq_wp <= r_dq_wp + PW'(1);
      if (w_dq_pop) r_dq_rp <= r_dq_rp + PW'(1);
      r_dq_cnt <= cnt_upd(r_dq_cnt, w_r_end, w_dq_pop);
      if (w_sq_push) r_sq_wp <= r_sq_wp + PW'(1);
      if (w_sq_pop)  r_sq_rp <= r_sq_rp + PW'(1);
      r_sq_cnt  <= cnt_upd(r_sq_cnt, w_sq_push, w_sq_pop);
      r_state   <= w_state_nxt;
      r_st_beat <= w_beat_nxt;
      r_aw_acc  <= w_aw_acc_nxt;
      r_w_acc   <= w_w_acc_nxt;
      case ({w_beat_done, w_b_dec})
        2'b10:   r_b_out <= r_b_out + OBW'(1);
        2'b01:   r_b_out <= r_b_out - OBW'(1);
        default: r_b_out <= r_b_out;
      endcase
      r_grp_closed <= w_pop_last | (r_grp_closed & ~rvv_done_st);
      if (rvv_done_st)  r_err <= 1'b0;
      else if (w_b_dec) r_err <= r_err | mbus_b_resp;
    end
  end
endmodule
